// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end constants, fetch FSM state encoding and IF/ID payload.
// Pure declarations: no logic, no latency, no flow control.
// Used by the fetch unit and the next-PC selector.
package rv32i_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] fallback_pc;
    } if_id_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Request side is valid/ready; the response side is a bare valid strobe.
// The memory cannot stall a response; the fetch unit always accepts one.
interface if_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with bubble > load > hold priority.
// Latency: one cycle from load/bubble to output.
// No backpressure of its own: deasserting both controls holds the contents.
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output logic   valid,
    output if_id_t q
);

    // A bubble only clears valid/instr; pc and fallback keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid         <= 1'b0;
            q.pc          <= 32'h0;
            q.instr       <= NOP_INSTR;
            q.fallback_pc <= NOP_INSTR;
        end else if (bubble) begin
            valid   <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight, fills IF/ID.
// Latency: 2 cycles per instruction at 1-cycle imem (request, then response).
// Backpressure: id_stall parks a response in a hold buffer; flushes drain stale fetches. Optional counters: FETCH_PERF_CNT_EN.
module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             next_pc,
    input  logic [31:0]             fallback_pc_in,
    input  logic                    misprediction,
    input  logic                    id_stall,
    output logic [31:0]             pc,
    if_fetch_unit_if.master         imem,
    output logic                    if_id_valid,
    output logic [31:0]             if_id_pc,
    output logic [31:0]             if_id_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]             fetch_cnt,
    output logic [31:0]             flush_cnt,
`endif
    output logic [31:0]             if_id_fallback_pc
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  hold_q;
    logic         req_hs;
    logic         load;
    logic         bubble;
    logic [31:0]  load_instr;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    assign imem.imem_req_valid = (state == S_REQ);
    assign imem.imem_addr      = pc_q;
    assign pc                  = pc_q;
    assign req_hs              = (state == S_REQ) && imem.imem_req_ready;

    always_comb begin
        load       = 1'b0;
        load_instr = imem.imem_rsp_data;
        if (!misprediction) begin
            case (state)
                S_WAIT: load = imem.imem_rsp_valid && !id_stall;
                S_HOLD: begin
                    load       = !id_stall;
                    load_instr = hold_q;
                end
                default: load = 1'b0;
            endcase
        end
    end

    // Anything that is not a real load drains IF/ID unless decode is stalled.
    assign bubble  = misprediction || (!load && !id_stall);
    assign if_id_d = '{pc: pc_q, instr: load_instr, fallback_pc: fallback_pc_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_REQ;
            pc_q   <= RESET_PC;
            hold_q <= 32'h0;
        end else if (misprediction) begin
            pc_q <= next_pc;
            // An accepted-but-unanswered request must be drained; an unaccepted
            // one is simply re-aimed at the new PC.
            case (state)
                S_REQ:   state <= req_hs ? S_DRAIN : S_REQ;
                S_WAIT:  state <= imem.imem_rsp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  state <= S_REQ;
                S_DRAIN: state <= imem.imem_rsp_valid ? S_REQ : S_DRAIN;
                default: state <= S_REQ;
            endcase
        end else begin
            if (load) begin
                pc_q <= next_pc;
            end
            case (state)
                S_REQ: begin
                    if (req_hs) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (id_stall) begin
                            hold_q <= imem.imem_rsp_data;
                            state  <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bubble (bubble),
        .d      (if_id_d),
        .valid  (if_id_valid),
        .q      (if_id_q)
    );

    assign if_id_pc          = if_id_q.pc;
    assign if_id_instr       = if_id_q.instr;
    assign if_id_fallback_pc = if_id_q.fallback_pc;

`ifdef FETCH_PERF_CNT_EN
    // load is already gated by !misprediction, so every load is a valid one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (load) begin
                fetch_cnt <= fetch_cnt + 32'h1;
            end
            if (misprediction) begin
                flush_cnt <= flush_cnt + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against
// a transaction-level model (outstanding/killed/held fetch bookkeeping).
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] fallback_pc_in;
    logic        misprediction;
    logic        id_stall;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_fallback_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .next_pc           (next_pc),
        .fallback_pc_in    (fallback_pc_in),
        .misprediction     (misprediction),
        .id_stall          (id_stall),
        .pc                (pc),
        .imem              (bus),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instr       (if_id_instr),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt         (fetch_cnt),
        .flush_cnt         (flush_cnt),
`endif
        .if_id_fallback_pc (if_id_fallback_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic test_reset();
        rst = 1'b1; next_pc = 32'h0; fallback_pc_in = 32'h0; misprediction = 1'b0; id_stall = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_id_valid); else n_pass++;
        n_checks++; if (if_id_instr !== NOP) $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP); else n_pass++;
        n_checks++; if (if_id_pc !== 32'h0) $display("FAIL reset_ifid_pc: got %h want 0", if_id_pc); else n_pass++;
        n_checks++; if (if_id_fallback_pc !== NOP) $display("FAIL reset_fallback: got %h want %h", if_id_fallback_pc, NOP); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic_fetch();
        n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0)
            $display("FAIL first_req: got vld=%b addr=%h want vld=1 addr=0", bus.imem_req_valid, bus.imem_addr); else n_pass++;
        bus.imem_req_ready = 1'b1; next_pc = 32'h4; fallback_pc_in = 32'h1000;
        tick();
        n_checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL wait_no_req: got %b want 0", bus.imem_req_valid); else n_pass++;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0050_0093;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if ({if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc} !== {1'b1, 32'h0, 32'h0050_0093, 32'h1000})
            $display("FAIL fetch0: got v=%b pc=%h i=%h fb=%h want v=1 pc=0 i=00500093 fb=1000", if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h4 || bus.imem_req_valid !== 1'b1)
            $display("FAIL req1: got vld=%b addr=%h want vld=1 addr=4", bus.imem_req_valid, bus.imem_addr); else n_pass++;
        next_pc = 32'h8; fallback_pc_in = 32'h1004;
        tick();
        n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP)
            $display("FAIL gap_bubble: got v=%b i=%h want v=0 i=%h", if_id_valid, if_id_instr, NOP); else n_pass++;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0010_0113;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if ({if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc} !== {1'b1, 32'h4, 32'h0010_0113, 32'h1004})
            $display("FAIL fetch1: got v=%b pc=%h i=%h fb=%h want v=1 pc=4 i=00100113 fb=1004", if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc); else n_pass++;
    endtask

    task automatic test_stall();
        id_stall = 1'b1; next_pc = 32'hC;
        tick();
        n_checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4)
            $display("FAIL stall_frozen0: got v=%b pc=%h want v=1 pc=4", if_id_valid, if_id_pc); else n_pass++;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0020_0193;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if (bus.imem_req_valid !== 1'b0 || if_id_instr !== 32'h0010_0113)
            $display("FAIL stall_frozen1: got vld=%b i=%h want vld=0 i=00100113", bus.imem_req_valid, if_id_instr); else n_pass++;
        tick();
        n_checks++; if (bus.imem_req_valid !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h4)
            $display("FAIL stall_frozen2: got req=%b v=%b pc=%h want req=0 v=1 pc=4", bus.imem_req_valid, if_id_valid, if_id_pc); else n_pass++;
        id_stall = 1'b0; fallback_pc_in = 32'h2008;
        tick();
        n_checks++; if ({if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc} !== {1'b1, 32'h8, 32'h0020_0193, 32'h2008})
            $display("FAIL stall_release: got v=%b pc=%h i=%h fb=%h want v=1 pc=8 i=00200193 fb=2008", if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc); else n_pass++;
        n_checks++; if (pc !== 32'hC || bus.imem_req_valid !== 1'b1)
            $display("FAIL stall_next_req: got pc=%h req=%b want pc=c req=1", pc, bus.imem_req_valid); else n_pass++;
    endtask

    task automatic test_mispred_wait();
        id_stall = 1'b1; next_pc = 32'h10;
        tick();
        misprediction = 1'b1; next_pc = 32'h40;
        tick();
        n_checks++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b0, NOP, 32'h8})
            $display("FAIL flush_bubble: got v=%b i=%h pc=%h want v=0 i=%h pc=8", if_id_valid, if_id_instr, if_id_pc, NOP); else n_pass++;
        n_checks++; if (pc !== 32'h40 || bus.imem_req_valid !== 1'b0)
            $display("FAIL flush_drain: got pc=%h req=%b want pc=40 req=0", pc, bus.imem_req_valid); else n_pass++;
        misprediction = 1'b0; id_stall = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_0BAD;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP)
            $display("FAIL late_rsp_dropped: got v=%b i=%h want v=0 i=%h", if_id_valid, if_id_instr, NOP); else n_pass++;
        n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h40)
            $display("FAIL post_drain_req: got vld=%b addr=%h want vld=1 addr=40", bus.imem_req_valid, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_mispred_rsp();
        next_pc = 32'h44;
        tick();
        misprediction = 1'b1; next_pc = 32'h40;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0030_0213;
        tick();
        misprediction = 1'b0; bus.imem_rsp_valid = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP)
            $display("FAIL flush_rsp_discard: got v=%b i=%h want v=0 i=%h", if_id_valid, if_id_instr, NOP); else n_pass++;
        n_checks++; if (pc !== 32'h40 || bus.imem_req_valid !== 1'b1)
            $display("FAIL flush_rsp_req: got pc=%h req=%b want pc=40 req=1", pc, bus.imem_req_valid); else n_pass++;
    endtask

    task automatic test_ready_low();
        logic [31:0] exp_addr;
        bus.imem_req_ready = 1'b0; next_pc = 32'h80;
        for (int c = 0; c < 4; c++) begin
            misprediction = (c == 1);
            tick();
            exp_addr = (c >= 1) ? 32'h80 : 32'h40;
            n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== exp_addr)
                $display("FAIL ready_low_c%0d: got vld=%b addr=%h want vld=1 addr=%h", c, bus.imem_req_valid, bus.imem_addr, exp_addr); else n_pass++;
        end
        misprediction = 1'b0; bus.imem_req_ready = 1'b1; next_pc = 32'h84; fallback_pc_in = 32'h3080;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0040_0293;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if ({if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc} !== {1'b1, 32'h80, 32'h0040_0293, 32'h3080})
            $display("FAIL withdraw_fetch: got v=%b pc=%h i=%h fb=%h want v=1 pc=80 i=00400293 fb=3080", if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc); else n_pass++;
    endtask

    task automatic test_reset_midfetch();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc} !== {1'b0, 32'h0, NOP, NOP})
            $display("FAIL async_reset_ifid: got v=%b pc=%h i=%h fb=%h want v=0 pc=0 i=%h fb=%h", if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc, NOP, NOP); else n_pass++;
        n_checks++; if (pc !== 32'h0 || bus.imem_req_valid !== 1'b1)
            $display("FAIL async_reset_pc: got pc=%h req=%b want pc=0 req=1", pc, bus.imem_req_valid); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBADB_AD00;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0)
            $display("FAIL stale_rsp: got v=%b req=%b addr=%h want v=0 req=1 addr=0", if_id_valid, bus.imem_req_valid, bus.imem_addr); else n_pass++;
        bus.imem_req_ready = 1'b1; next_pc = 32'h4;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0050_0313;
        tick();
        bus.imem_rsp_valid = 1'b0;
        n_checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h0, 32'h0050_0313})
            $display("FAIL post_reset_fetch: got v=%b pc=%h i=%h want v=1 pc=0 i=00500313", if_id_valid, if_id_pc, if_id_instr); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_hdata, e_pc, e_instr, e_fb, e_fetch, e_flush, mem_data, req_addr, ld_data;
        logic        m_out, m_kill, m_held, e_valid, m_req, hs, rv, loaded, mem_pend;
        int          mem_cnt;
        m_pc = 32'h0; m_hdata = 32'h0; m_out = 1'b0; m_kill = 1'b0; m_held = 1'b0;
        e_valid = 1'b0; e_pc = 32'h0; e_instr = NOP; e_fb = NOP; e_fetch = 32'h0; e_flush = 32'h0;
        mem_pend = 1'b0; mem_cnt = 0; mem_data = 32'h0;
        misprediction = 1'b0; id_stall = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_req = !m_out && !m_held;
            n_checks++; if (bus.imem_req_valid !== m_req || (m_req && bus.imem_addr !== m_pc))
                $display("FAIL rnd_req@%0d: got vld=%b addr=%h want vld=%b addr=%h", cyc, bus.imem_req_valid, bus.imem_addr, m_req, m_pc); else n_pass++;
            n_checks++; if ({if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc} !== {e_valid, e_pc, e_instr, e_fb})
                $display("FAIL rnd_ifid@%0d: got v=%b pc=%h i=%h fb=%h want v=%b pc=%h i=%h fb=%h", cyc,
                         if_id_valid, if_id_pc, if_id_instr, if_id_fallback_pc, e_valid, e_pc, e_instr, e_fb); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
            n_checks++; if (fetch_cnt !== e_fetch || flush_cnt !== e_flush)
                $display("FAIL rnd_cnt@%0d: got f=%0d x=%0d want f=%0d x=%0d", cyc, fetch_cnt, flush_cnt, e_fetch, e_flush); else n_pass++;
`endif
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            id_stall           = ($urandom_range(0, 3) == 0);
            misprediction      = ($urandom_range(0, 9) == 0);
            next_pc            = $urandom & 32'hFFFF_FFFC;
            fallback_pc_in     = $urandom;
            rv = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    rv = 1'b1; mem_pend = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            bus.imem_rsp_valid = rv;
            bus.imem_rsp_data  = rv ? mem_data : $urandom;
            hs = m_req && bus.imem_req_ready;
            req_addr = m_pc;
            loaded = 1'b0; ld_data = 32'h0;
            if (misprediction) begin
                e_valid = 1'b0; e_instr = NOP; e_flush++;
                if (hs) begin
                    m_out = 1'b1; m_kill = 1'b1;
                end else if (rv) begin
                    m_out = 1'b0;
                end else if (m_out) begin
                    m_kill = 1'b1;
                end
                m_held = 1'b0;
                m_pc = next_pc;
            end else begin
                if (rv) begin
                    m_out = 1'b0;
                    if (!m_kill) begin
                        if (id_stall) begin
                            m_held = 1'b1; m_hdata = mem_data;
                        end else begin
                            loaded = 1'b1; ld_data = mem_data;
                        end
                    end
                end else if (m_held && !id_stall) begin
                    loaded = 1'b1; ld_data = m_hdata; m_held = 1'b0;
                end
                if (loaded) begin
                    e_valid = 1'b1; e_pc = m_pc; e_instr = ld_data; e_fb = fallback_pc_in;
                    m_pc = next_pc; e_fetch++;
                end else if (!id_stall) begin
                    e_valid = 1'b0; e_instr = NOP;
                end
                if (hs) begin
                    m_out = 1'b1; m_kill = 1'b0;
                end
            end
            if (hs) begin
                mem_pend = 1'b1; mem_cnt = $urandom_range(0, 2); mem_data = mem_word(req_addr);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_mispred_wait();
        test_mispred_rsp();
        test_ready_low();
        test_reset_midfetch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
